// File: rtl/wide_dma_superbank_adapter.sv
// Splits one wide DMA memory request across independently granted TCDM superbanks and
// merges the slice responses back into one response, 1 cycle after the upstream grant.
module wide_dma_superbank_adapter #(
  parameter int unsigned NB_SUPERBANKS = 4,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned ADDR_WIDTH    = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                mem_req_i,
  output logic                                mem_gnt_o,
  input  logic [ADDR_WIDTH-1:0]               mem_add_i,
  input  logic                                mem_wen_i,
  input  logic [DATA_WIDTH-1:0]               mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]             mem_be_i,
  output logic                                mem_r_valid_o,
  output logic [DATA_WIDTH-1:0]               mem_r_rdata_o,
  output logic [NB_SUPERBANKS-1:0]            sb_req_o,
  input  logic [NB_SUPERBANKS-1:0]            sb_gnt_i,
  output logic [ADDR_WIDTH-1:0]               sb_add_o,
  output logic                                sb_wen_o,
  output logic [DATA_WIDTH-1:0]               sb_wdata_o,
  output logic [DATA_WIDTH/8-1:0]             sb_be_o,
  input  logic [DATA_WIDTH-1:0]               sb_r_rdata_i
);

  localparam int unsigned SbDw = DATA_WIDTH / NB_SUPERBANKS;
  localparam int unsigned SbBe = SbDw / 8;

  logic [NB_SUPERBANKS-1:0]           needed;
  logic [NB_SUPERBANKS-1:0]           done_q, done_d;
  logic [NB_SUPERBANKS-1:0]           late_q;
  logic [NB_SUPERBANKS-1:0]           sb_fire;
  logic [NB_SUPERBANKS-1:0][SbDw-1:0] buf_q;

  // Reads touch every slice; writes only the slices with at least one enabled byte.
  always_comb begin
    needed = '0;
    for (int k = 0; k < NB_SUPERBANKS; k++) begin
      needed[k] = mem_wen_i ? |mem_be_i[k*SbBe +: SbBe] : 1'b1;
    end
  end

  assign sb_req_o   = {NB_SUPERBANKS{mem_req_i}} & needed & ~done_q;
  assign sb_fire    = sb_req_o & sb_gnt_i;
  assign mem_gnt_o  = mem_req_i & (&(~needed | done_q | sb_gnt_i));

  assign sb_add_o   = mem_add_i;
  assign sb_wen_o   = mem_wen_i;
  assign sb_wdata_o = mem_wdata_i;
  assign sb_be_o    = mem_be_i;

  always_comb begin
    done_d = done_q | sb_fire;
    if (mem_gnt_o) begin
      done_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q        <= '0;
      late_q        <= '0;
      mem_r_valid_o <= 1'b0;
    end else begin
      done_q        <= done_d;
      late_q        <= sb_fire;
      mem_r_valid_o <= mem_gnt_o;
    end
  end

  // Slices granted early are parked here until the merged response cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
    end else begin
      for (int k = 0; k < NB_SUPERBANKS; k++) begin
        if (late_q[k]) begin
          buf_q[k] <= sb_r_rdata_i[k*SbDw +: SbDw];
        end
      end
    end
  end

  always_comb begin
    mem_r_rdata_o = '0;
    for (int k = 0; k < NB_SUPERBANKS; k++) begin
      mem_r_rdata_o[k*SbDw +: SbDw] = late_q[k] ? sb_r_rdata_i[k*SbDw +: SbDw] : buf_q[k];
    end
  end

endmodule
